oc_csr_host_arbiter: RTL and testbench

//  Shares the top-level CSR bus between several host requesters (UART control, JTAG, future PCIe).

---
 rtl/oclib_pkg.sv | 26 ++
 rtl/oclib_rr_arbiter.sv | 39 +++
 rtl/oc_csr_host_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_oc_csr_host_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oclib_pkg.sv
// Shared types for the oclib CSR infrastructure: host-arbiter FSM states,
// the flat CSR request record and small elaboration-time helpers.
package oclib_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } csr_arb_state_e;

    localparam int unsigned CsrFlatAddrWidth = 32;
    localparam int unsigned CsrFlatDataWidth = 32;

    typedef struct packed {
        logic                        write;
        logic [CsrFlatAddrWidth-1:0] address;
        logic [CsrFlatDataWidth-1:0] wdata;
    } csr_flat_req_s;

    // Index width that never collapses to zero bits for a single requester.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/oclib_rr_arbiter.sv
// Combinational round-robin pick: first requesting index strictly after
// pointer_i, wrapping; the pointer register lives in the instantiating block.
module oclib_rr_arbiter
    import oclib_pkg::*;
#(
    parameter  int unsigned Requesters = 2,
    localparam int unsigned IdxWidth   = clog2_min1(Requesters)
) (
    input  logic [Requesters-1:0] request_i,
    input  logic [IdxWidth-1:0]   pointer_i,
    output logic [Requesters-1:0] grant_o,
    output logic [IdxWidth-1:0]   index_o,
    output logic                  any_o
);

    if (Requesters == 1) begin : g_single
        assign grant_o = request_i;
        assign index_o = '0;
        assign any_o   = request_i[0];
    end else begin : g_multi
        logic [IdxWidth-1:0] cand;

        always_comb begin
            grant_o = '0;
            index_o = '0;
            any_o   = 1'b0;
            cand    = '0;
            for (int unsigned i = 1; i <= Requesters; i++) begin
                cand = IdxWidth'((32'(pointer_i) + i) % Requesters);
                if (!any_o && request_i[cand]) begin
                    grant_o[cand] = 1'b1;
                    index_o       = cand;
                    any_o         = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/oc_csr_host_arbiter.sv
// Round-robin sharing of the flat CSR bus between host requesters, one
// transaction outstanding. Optional downstream timeout: OC_CSR_HOST_ARBITER_TIMEOUT_EN.
module oc_csr_host_arbiter
    import oclib_pkg::*;
#(
    parameter  int unsigned Requesters    = 2,
    parameter  int unsigned AddressWidth  = 32,
    parameter  int unsigned DataWidth     = 32,
    parameter  int unsigned TimeoutCycles = 4096,
    localparam int unsigned OwnerWidth    = clog2_min1(Requesters)
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [Requesters-1:0]                   reqValid,
    output logic [Requesters-1:0]                   reqReady,
    input  logic [Requesters-1:0]                   reqWrite,
    input  logic [Requesters-1:0][AddressWidth-1:0] reqAddress,
    input  logic [Requesters-1:0][DataWidth-1:0]    reqWdata,
    output logic [Requesters-1:0]                   respValid,
    output logic [DataWidth-1:0]                    respRdata,
    output logic                                    respError,
    output logic                                    csrValid,
    input  logic                                    csrReady,
    output logic                                    csrWrite,
    output logic [AddressWidth-1:0]                 csrAddress,
    output logic [DataWidth-1:0]                    csrWdata,
    input  logic                                    csrRespValid,
    input  logic [DataWidth-1:0]                    csrRdata,
    input  logic                                    csrError,
    output logic [OwnerWidth-1:0]                   grantOwner,
`ifdef OC_CSR_HOST_ARBITER_TIMEOUT_EN
    output logic [15:0]                             timeoutCount,
`endif
    output logic                                    busy
);

    if (Requesters < 1 || Requesters > 8 || TimeoutCycles < 2) begin : g_param_check
        $error("oc_csr_host_arbiter: parameter out of range");
    end

    typedef struct packed {
        logic                    write;
        logic [AddressWidth-1:0] address;
        logic [DataWidth-1:0]    wdata;
    } req_t;

    csr_arb_state_e          state_q;
    logic [OwnerWidth-1:0]   ptr_q;
    logic [OwnerWidth-1:0]   owner_q;
    logic [Requesters-1:0]   reqReady_q;
    logic [Requesters-1:0]   respValid_q;
    req_t                    req_q;
    logic [DataWidth-1:0]    rdata_q;
    logic                    error_q;
    logic                    csrValid_q;

    logic [Requesters-1:0]   arb_grant;
    logic [OwnerWidth-1:0]   arb_idx;
    logic                    arb_any;
    logic                    tmo_fire;

    oclib_rr_arbiter #(
        .Requesters (Requesters)
    ) u_rr (
        .request_i (reqValid),
        .pointer_i (ptr_q),
        .grant_o   (arb_grant),
        .index_o   (arb_idx),
        .any_o     (arb_any)
    );

`ifdef OC_CSR_HOST_ARBITER_TIMEOUT_EN
    localparam int unsigned CntWidth = clog2_min1(TimeoutCycles);

    logic [CntWidth-1:0] tmoCnt_q;
    logic [15:0]         tmoTotal_q;
    logic                tmo_hit;

    assign tmo_hit = (tmoCnt_q == CntWidth'(TimeoutCycles - 1));

    // A real response arriving in the expiry cycle takes priority over the timeout.
    always_comb begin
        tmo_fire = 1'b0;
        if (state_q == ISSUE) tmo_fire = tmo_hit && !(csrReady && csrRespValid);
        if (state_q == WAIT)  tmo_fire = tmo_hit && !csrRespValid;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tmoCnt_q   <= '0;
            tmoTotal_q <= '0;
        end else begin
            if (state_q == ISSUE || state_q == WAIT) begin
                if (!tmo_hit) tmoCnt_q <= tmoCnt_q + 1'b1;
            end else begin
                tmoCnt_q <= '0;
            end
            if (tmo_fire && tmoTotal_q != 16'hFFFF) tmoTotal_q <= tmoTotal_q + 1'b1;
        end
    end

    assign timeoutCount = tmoTotal_q;
`else
    assign tmo_fire = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= OwnerWidth'(Requesters - 1);
            owner_q     <= '0;
            reqReady_q  <= '0;
            respValid_q <= '0;
            req_q       <= '0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
            csrValid_q  <= 1'b0;
        end else begin
            reqReady_q  <= '0;
            respValid_q <= '0;
            unique case (state_q)
                // Skipping arbitration while the response is presented spaces grants 4 clocks apart.
                IDLE: if (arb_any && !respValid_q) begin
                    reqReady_q    <= arb_grant;
                    req_q.write   <= reqWrite[arb_idx];
                    req_q.address <= reqAddress[arb_idx];
                    req_q.wdata   <= reqWdata[arb_idx];
                    owner_q       <= arb_idx;
                    ptr_q         <= arb_idx;
                    csrValid_q    <= 1'b1;
                    state_q       <= ISSUE;
                end
                ISSUE: begin
                    if (csrReady && csrRespValid) begin
                        csrValid_q <= 1'b0;
                        rdata_q    <= csrRdata;
                        error_q    <= csrError;
                        state_q    <= RESP;
                    end else if (tmo_fire) begin
                        csrValid_q <= 1'b0;
                        rdata_q    <= '0;
                        error_q    <= 1'b1;
                        state_q    <= RESP;
                    end else if (csrReady) begin
                        csrValid_q <= 1'b0;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (csrRespValid) begin
                        rdata_q <= csrRdata;
                        error_q <= csrError;
                        state_q <= RESP;
                    end else if (tmo_fire) begin
                        rdata_q <= '0;
                        error_q <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    respValid_q <= Requesters'(1) << owner_q;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign reqReady   = reqReady_q;
    assign respValid  = respValid_q;
    assign respRdata  = rdata_q;
    assign respError  = error_q;
    assign csrValid   = csrValid_q;
    assign csrWrite   = req_q.write;
    assign csrAddress = req_q.address;
    assign csrWdata   = req_q.wdata;
    assign grantOwner = owner_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_oc_csr_host_arbiter.sv
// Directed bench for oc_csr_host_arbiter: transaction table plus hand-written
// backpressure, stray-response, reset-abort and (with the macro) timeout sequences.
module tb_oc_csr_host_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
`ifdef OC_CSR_HOST_ARBITER_TIMEOUT_EN
    localparam int unsigned TMO = 16;
`else
    localparam int unsigned TMO = 4096;
`endif

    logic                    clock;
    logic                    reset;
    logic [NR-1:0]           reqValid;
    logic [NR-1:0]           reqReady;
    logic [NR-1:0]           reqWrite;
    logic [NR-1:0][AW-1:0]   reqAddress;
    logic [NR-1:0][DW-1:0]   reqWdata;
    logic [NR-1:0]           respValid;
    logic [DW-1:0]           respRdata;
    logic                    respError;
    logic                    csrValid;
    logic                    csrReady;
    logic                    csrWrite;
    logic [AW-1:0]           csrAddress;
    logic [DW-1:0]           csrWdata;
    logic                    csrRespValid;
    logic [DW-1:0]           csrRdata;
    logic                    csrError;
    logic [0:0]              grantOwner;
    logic                    busy;
`ifdef OC_CSR_HOST_ARBITER_TIMEOUT_EN
    logic [15:0]             timeoutCount;
`endif

    oc_csr_host_arbiter #(
        .Requesters    (NR),
        .AddressWidth  (AW),
        .DataWidth     (DW),
        .TimeoutCycles (TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .reqValid     (reqValid),
        .reqReady     (reqReady),
        .reqWrite     (reqWrite),
        .reqAddress   (reqAddress),
        .reqWdata     (reqWdata),
        .respValid    (respValid),
        .respRdata    (respRdata),
        .respError    (respError),
        .csrValid     (csrValid),
        .csrReady     (csrReady),
        .csrWrite     (csrWrite),
        .csrAddress   (csrAddress),
        .csrWdata     (csrWdata),
        .csrRespValid (csrRespValid),
        .csrRdata     (csrRdata),
        .csrError     (csrError),
        .grantOwner   (grantOwner),
`ifdef OC_CSR_HOST_ARBITER_TIMEOUT_EN
        .timeoutCount (timeoutCount),
`endif
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  wr;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic [31:0] rdata;
        logic        err;
        int unsigned owner;
        int unsigned lat;   // 0 = latency not checked
    } vec_t;

    vec_t vecs[8];

    // Downstream accepts and answers in the ISSUE cycle; the granted requester drops its valid.
    task automatic run_vec(input int unsigned n, input vec_t v);
        int unsigned cyc;
        logic        got;
        logic [1:0]  oh;
        oh = 2'b01 << v.owner;
        reqValid      = v.valid;
        reqWrite      = v.wr;
        reqAddress[0] = v.addr0;
        reqAddress[1] = v.addr1;
        reqWdata[0]   = v.wd0;
        reqWdata[1]   = v.wd1;
        csrRdata      = v.rdata;
        csrError      = v.err;
        csrReady      = 1'b1;
        csrRespValid  = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            tick();
            cyc++;
            if (reqReady != '0) got = 1'b1;
        end
        check($sformatf("v%0d_reqReady", n), reqReady, oh);
        reqValid[v.owner] = 1'b0;
        check($sformatf("v%0d_csrValid", n), csrValid, 1);
        check($sformatf("v%0d_csrAddress", n), csrAddress, (v.owner == 1) ? v.addr1 : v.addr0);
        check($sformatf("v%0d_csrWrite", n), csrWrite, v.wr[v.owner]);
        check($sformatf("v%0d_csrWdata", n), csrWdata, (v.owner == 1) ? v.wd1 : v.wd0);
        check($sformatf("v%0d_grantOwner", n), grantOwner, v.owner);
        got = 1'b0;
        while (!got && cyc < 40) begin
            tick();
            cyc++;
            if (respValid != '0) got = 1'b1;
        end
        check($sformatf("v%0d_respValid", n), respValid, oh);
        check($sformatf("v%0d_respRdata", n), respRdata, v.rdata);
        check($sformatf("v%0d_respError", n), respError, v.err);
        if (v.lat != 0) check($sformatf("v%0d_latency", n), cyc, v.lat);
    endtask

    initial begin
        int unsigned pulses;
        int unsigned cyc;
        logic        got;

        //            valid  wr     addr0         addr1         wd0           wd1           rdata         err   own lat
        vecs[0] = '{2'b01, 2'b00, 32'h0000_0010, 32'h0,        32'h0,        32'h0,        32'hCAFE_F00D, 1'b0, 0, 3};
        vecs[1] = '{2'b10, 2'b00, 32'h0,        32'h0000_0020, 32'h0,        32'h0,        32'h0202_0202, 1'b0, 1, 0};
        vecs[2] = '{2'b11, 2'b01, 32'h0000_0100, 32'h0000_0200, 32'hA0A0_0001, 32'hB0B0_0001, 32'h1111_0001, 1'b0, 0, 0};
        vecs[3] = '{2'b11, 2'b10, 32'h0000_0104, 32'h0000_0204, 32'hA0A0_0002, 32'hB0B0_0002, 32'h1111_0002, 1'b0, 1, 0};
        vecs[4] = '{2'b11, 2'b00, 32'h0000_0108, 32'h0000_0208, 32'hA0A0_0003, 32'hB0B0_0003, 32'h1111_0003, 1'b0, 0, 0};
        vecs[5] = '{2'b11, 2'b11, 32'h0000_010C, 32'h0000_020C, 32'hA0A0_0004, 32'hB0B0_0004, 32'h1111_0004, 1'b0, 1, 0};
        vecs[6] = '{2'b10, 2'b10, 32'h0,        32'h0000_0040, 32'h0,        32'h0000_1234, 32'hDEAD_BEEF, 1'b1, 1, 0};
        vecs[7] = '{2'b01, 2'b00, 32'h0000_0044, 32'h0,        32'h0,        32'h0,        32'h5555_AAAA, 1'b0, 0, 0};

        reset        = 1'b1;
        reqValid     = '0;
        reqWrite     = '0;
        reqAddress   = '0;
        reqWdata     = '0;
        csrReady     = 1'b0;
        csrRespValid = 1'b0;
        csrRdata     = '0;
        csrError     = 1'b0;
        tick();
        tick();
        check("rst_reqReady", reqReady, 0);
        check("rst_respValid", respValid, 0);
        check("rst_csrValid", csrValid, 0);
        check("rst_busy", busy, 0);
        check("rst_grantOwner", grantOwner, 0);
        check("rst_respError", respError, 0);
        check("rst_respRdata", respRdata, 0);
        reset = 1'b0;
        tick();

        for (int unsigned i = 0; i < 8; i++) run_vec(i, vecs[i]);
        reqValid     = '0;
        csrRespValid = 1'b0;
        csrReady     = 1'b0;
        tick();
        tick();

        // Backpressure: request held stable while csrReady stays low for 10 clocks.
        reqWrite      = 2'b01;
        reqAddress[0] = 32'h0000_ABC0;
        reqWdata[0]   = 32'h1111_2222;
        reqValid      = 2'b01;
        pulses = 0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            tick();
            cyc++;
            if (reqReady != '0) got = 1'b1;
        end
        check("bp_grant", reqReady, 2'b01);
        reqValid = '0;
        pulses++;
        for (int unsigned i = 0; i < 10; i++) begin
            check($sformatf("bp_csrValid_%0d", i), csrValid, 1);
            check($sformatf("bp_csrAddress_%0d", i), csrAddress, 32'h0000_ABC0);
            check($sformatf("bp_csrWdata_%0d", i), csrWdata, 32'h1111_2222);
            tick();
            if (reqReady != '0) pulses++;
        end
        csrReady = 1'b1;
        tick();
        if (reqReady != '0) pulses++;
        csrReady = 1'b0;
        check("bp_wait_csrValid", csrValid, 0);
        check("bp_wait_busy", busy, 1);
        csrRdata     = 32'h0BAD_F00D;
        csrError     = 1'b0;
        csrRespValid = 1'b1;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 10) begin
            tick();
            cyc++;
            if (reqReady != '0) pulses++;
            if (respValid != '0) got = 1'b1;
        end
        check("bp_respValid", respValid, 2'b01);
        check("bp_respRdata", respRdata, 32'h0BAD_F00D);
        check("bp_reqReady_pulses", pulses, 1);

        // Responses with nothing outstanding must be ignored.
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stray_respValid_%0d", i), respValid, 0);
            check($sformatf("stray_busy_%0d", i), busy, 0);
        end
        csrRespValid = 1'b0;

        // Reset while waiting for the downstream response.
        reqAddress[0] = 32'h0000_0300;
        reqWrite      = 2'b00;
        reqValid      = 2'b01;
        csrReady      = 1'b1;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 20) begin
            tick();
            cyc++;
            if (reqReady != '0) got = 1'b1;
        end
        check("rw_grant", reqReady, 2'b01);
        reqValid = '0;
        tick();
        check("rw_in_wait_busy", busy, 1);
        check("rw_in_wait_csrValid", csrValid, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rw_after_busy", busy, 0);
        check("rw_after_csrValid", csrValid, 0);
        csrRdata     = 32'h7777_7777;
        csrRespValid = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rw_stray_respValid_%0d", i), respValid, 0);
            check($sformatf("rw_stray_busy_%0d", i), busy, 0);
        end
        reqAddress[1] = 32'h0000_0400;
        reqValid      = 2'b11;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 20) begin
            tick();
            cyc++;
            if (reqReady != '0) got = 1'b1;
        end
        check("rw_next_grant", reqReady, 2'b01);
        reqValid = '0;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 20) begin
            tick();
            cyc++;
            if (respValid != '0) got = 1'b1;
        end
        check("rw_next_respValid", respValid, 2'b01);
        check("rw_next_respRdata", respRdata, 32'h7777_7777);
        csrRespValid = 1'b0;
        tick();

`ifdef OC_CSR_HOST_ARBITER_TIMEOUT_EN
        // Timeout: RESP entered 16 clocks after ISSUE entry, respValid registered one clock later.
        check("to_count_initial", timeoutCount, 0);
        reqAddress[0] = 32'h0000_0500;
        reqValid      = 2'b01;
        csrReady      = 1'b1;
        csrRespValid  = 1'b0;
        csrRdata      = 32'hFFFF_FFFF;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 20) begin
            tick();
            cyc++;
            if (reqReady != '0) got = 1'b1;
        end
        check("to_grant", reqReady, 2'b01);
        reqValid = '0;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 40) begin
            tick();
            cyc++;
            if (respValid != '0) got = 1'b1;
        end
        check("to_respValid", respValid, 2'b01);
        check("to_latency", cyc, 17);
        check("to_respError", respError, 1);
        check("to_respRdata", respRdata, 0);
        check("to_count", timeoutCount, 1);
        csrRespValid = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            check($sformatf("to_late_respValid_%0d", i), respValid, 0);
            check($sformatf("to_late_busy_%0d", i), busy, 0);
        end
        check("to_count_after", timeoutCount, 1);
        csrRespValid = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
